// File: rtl/speicher_arbiter.sv
// -----------------------------------------------------------------------------
// speicher_arbiter
//
// Shares one single-ported memory between KANAELE requesters (channel 0 is
// instruction fetch, channel 1 data load/store, further channels optional).
// In FREI one requesting channel is picked, either by fixed priority (lowest
// index) or round-robin starting after the channel granted last. Its address,
// write data and direction are registered. In AKTIV exactly one memory strobe
// is held until SpeicherFertig or a timeout. ABSCHLUSS is a one-cycle gap that
// carries the Fertig/Fehler pulse and grants nothing, so a request that is
// still high while its completion is signalled is not served twice.
//
// Ports
//   Clock              rising-edge clock
//   Reset              asynchronous reset, active-low
//   Lesen              per-channel read request (level)
//   Schreiben          per-channel write request (level, wins over Lesen)
//   Adresse            per-channel address, channel i at [i*ADRESSBREITE +: ADRESSBREITE]
//   DatenSchreiben     per-channel write data, sliced the same way
//   DatenGelesen       last read value, valid while a read's Fertig bit is high
//   Fertig             per-channel one-cycle completion pulse
//   Fehler             per-channel one-cycle timeout pulse
//   SpeicherLesen      memory read strobe
//   SpeicherSchreiben  memory write strobe
//   SpeicherAdresse    memory address
//   SpeicherDatenRaus  memory write data
//   SpeicherDatenRein  memory read data
//   SpeicherFertig     memory completion pulse
// -----------------------------------------------------------------------------
module speicher_arbiter #(
    parameter int DATENBREITE  = 32,
    parameter int ADRESSBREITE = 32,
    parameter int KANAELE      = 2,
    parameter int MODUS        = 1,
    parameter int ZEITLIMIT    = 255
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [KANAELE-1:0]              Lesen,
    input  logic [KANAELE-1:0]              Schreiben,
    input  logic [KANAELE*ADRESSBREITE-1:0] Adresse,
    input  logic [KANAELE*DATENBREITE-1:0]  DatenSchreiben,
    output logic [DATENBREITE-1:0]          DatenGelesen,
    output logic [KANAELE-1:0]              Fertig,
    output logic [KANAELE-1:0]              Fehler,
    output logic                            SpeicherLesen,
    output logic                            SpeicherSchreiben,
    output logic [ADRESSBREITE-1:0]         SpeicherAdresse,
    output logic [DATENBREITE-1:0]          SpeicherDatenRaus,
    input  logic [DATENBREITE-1:0]          SpeicherDatenRein,
    input  logic                            SpeicherFertig
);

    localparam int KW = (KANAELE > 1) ? $clog2(KANAELE) : 1;
    // One extra bit so letzter + 1 + offset cannot overflow before the wrap.
    localparam int IW = KW + 1;
    localparam int CW = 16;

    localparam logic [1:0] FREI      = 2'd0;
    localparam logic [1:0] AKTIV     = 2'd1;
    localparam logic [1:0] ABSCHLUSS = 2'd2;

    logic [1:0]              state;
    logic [KW-1:0]           gewinner;
    logic [KW-1:0]           letzter;
    logic                    schreib_richtung;
    logic [ADRESSBREITE-1:0] adresse_reg;
    logic [DATENBREITE-1:0]  daten_reg;
    logic [DATENBREITE-1:0]  gelesen_reg;
    logic [CW-1:0]           warte_zaehler;
    logic [KANAELE-1:0]      fertig_reg;
    logic [KANAELE-1:0]      fehler_reg;

    logic [KANAELE-1:0]      anfrage;
    logic [IW-1:0]           such_idx;
    logic [KW-1:0]           kandidat;
    logic                    kandidat_gueltig;

    assign anfrage = Lesen | Schreiben;

    // Winner search: walk all channels once, starting at 0 (fixed priority)
    // or at letzter+1 with wrap-around (round-robin); first requester wins.
    always_comb begin
        kandidat         = '0;
        kandidat_gueltig = 1'b0;
        such_idx         = '0;
        for (int off = 0; off < KANAELE; off++) begin
            if (MODUS == 0) begin
                such_idx = IW'(off);
            end else begin
                such_idx = {1'b0, letzter} + IW'(off) + IW'(1);
                if (such_idx >= IW'(KANAELE)) begin
                    such_idx = such_idx - IW'(KANAELE);
                end
            end
            if (!kandidat_gueltig && anfrage[such_idx[KW-1:0]]) begin
                kandidat         = such_idx[KW-1:0];
                kandidat_gueltig = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state            <= FREI;
            gewinner         <= '0;
            letzter          <= KW'(KANAELE - 1);
            schreib_richtung <= 1'b0;
            adresse_reg      <= '0;
            daten_reg        <= '0;
            gelesen_reg      <= '0;
            warte_zaehler    <= '0;
            fertig_reg       <= '0;
            fehler_reg       <= '0;
        end else begin
            fertig_reg <= '0;
            fehler_reg <= '0;
            case (state)
                FREI: begin
                    if (kandidat_gueltig) begin
                        gewinner         <= kandidat;
                        letzter          <= kandidat;
                        adresse_reg      <= Adresse[int'(kandidat)*ADRESSBREITE +: ADRESSBREITE];
                        daten_reg        <= DatenSchreiben[int'(kandidat)*DATENBREITE +: DATENBREITE];
                        schreib_richtung <= Schreiben[kandidat];
                        warte_zaehler    <= '0;
                        state            <= AKTIV;
                    end
                end
                AKTIV: begin
                    // Completion is checked first so that a memory answer in
                    // the last allowed cycle still counts as success.
                    if (SpeicherFertig) begin
                        if (!schreib_richtung) begin
                            gelesen_reg <= SpeicherDatenRein;
                        end
                        fertig_reg[gewinner] <= 1'b1;
                        state                <= ABSCHLUSS;
                    end else if (warte_zaehler == CW'(ZEITLIMIT - 1)) begin
                        // This is the ZEITLIMIT-th strobe cycle without answer.
                        fehler_reg[gewinner] <= 1'b1;
                        warte_zaehler        <= warte_zaehler + 1'b1;
                        state                <= ABSCHLUSS;
                    end else begin
                        warte_zaehler <= warte_zaehler + 1'b1;
                    end
                end
                ABSCHLUSS: begin
                    state <= FREI;
                end
                default: begin
                    state <= FREI;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register, so they fall together
    // with the state on completion, timeout and asynchronous reset.
    assign SpeicherLesen     = (state == AKTIV) && !schreib_richtung;
    assign SpeicherSchreiben = (state == AKTIV) &&  schreib_richtung;
    assign SpeicherAdresse   = adresse_reg;
    assign SpeicherDatenRaus = daten_reg;
    assign DatenGelesen      = gelesen_reg;
    assign Fertig            = fertig_reg;
    assign Fehler            = fehler_reg;

endmodule
